// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file and its dump engine.
package regfile_pkg;

    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_RUN,
        DUMP_DONE
    } dump_state_e;

    localparam int DEF_BUS_DATA_WIDTH = 64;
    localparam int DEF_NUM_REGS       = 32;
    localparam int DEF_NUM_RD         = 2;
    localparam int DEF_NUM_WR         = 1;

    function automatic int reg_idx_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Operand read, writeback, issue and dump signals of the register file bundled as one interface.
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int BDW    = DEF_BUS_DATA_WIDTH,
    parameter int AW     = reg_idx_w(DEF_NUM_REGS),
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
);
    logic                    rd_en;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD-1:0]       rd_imm_sel;
    logic [NUM_RD*BDW-1:0]   rd_imm;
    logic [NUM_RD*BDW-1:0]   rd_data;
    logic [NUM_RD-1:0]       rd_busy;

    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*BDW-1:0]   wr_data;

    logic                    issue_en;
    logic [AW-1:0]           issue_rd;

    logic                    dump_req;
    logic                    dump_valid;
    logic                    dump_ready;
    logic [AW-1:0]           dump_idx;
    logic [BDW-1:0]          dump_data;
    logic                    dump_done;

    modport master (
        output rd_en, rd_addr, rd_imm_sel, rd_imm,
        input  rd_data, rd_busy,
        output wr_en, wr_addr, wr_data,
        output issue_en, issue_rd,
        output dump_req, dump_ready,
        input  dump_valid, dump_idx, dump_data, dump_done
    );

    modport slave (
        input  rd_en, rd_addr, rd_imm_sel, rd_imm,
        output rd_data, rd_busy,
        input  wr_en, wr_addr, wr_data,
        input  issue_en, issue_rd,
        input  dump_req, dump_ready,
        output dump_valid, dump_idx, dump_data, dump_done
    );
endinterface

// File: rtl/regfile_dump_fsm.sv
// Walks every register index once over a valid/ready port; the parent supplies the bypassed value
// for whichever index this engine asks for.
module regfile_dump_fsm import regfile_pkg::*; #(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BDW      = DEF_BUS_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            dump_req,
    input  logic                            dump_ready,
    output logic [reg_idx_w(NUM_REGS)-1:0]  lookup_idx,
    input  logic [BDW-1:0]                  lookup_data,
    output logic                            dump_valid,
    output logic [reg_idx_w(NUM_REGS)-1:0]  dump_idx,
    output logic [BDW-1:0]                  dump_data,
    output logic                            dump_done
);
    localparam int AW = reg_idx_w(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    dump_state_e    state_reg, state_next;
    logic [AW-1:0]  idx_reg, idx_next;
    logic [BDW-1:0] data_reg;
    logic           beat_accept;
    logic           load;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= DUMP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DUMP_IDLE: if (dump_req) state_next = DUMP_RUN;
            DUMP_RUN:  if (beat_accept && idx_reg == LAST_IDX) state_next = DUMP_DONE;
            DUMP_DONE: state_next = DUMP_IDLE;
            default:   state_next = DUMP_IDLE;
        endcase
    end

    // The next beat's value is captured on the same edge the current one is accepted,
    // so the presented data never changes while the consumer stalls.
    always_comb begin
        dump_valid  = (state_reg == DUMP_RUN);
        dump_done   = (state_reg == DUMP_DONE);
        beat_accept = dump_valid && dump_ready;
        load        = 1'b0;
        idx_next    = idx_reg;
        lookup_idx  = idx_reg + AW'(1);
        if (state_reg == DUMP_IDLE && dump_req) begin
            load       = 1'b1;
            idx_next   = '0;
            lookup_idx = '0;
        end else if (beat_accept && idx_reg != LAST_IDX) begin
            load       = 1'b1;
            idx_next   = idx_reg + AW'(1);
            lookup_idx = idx_reg + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_reg  <= '0;
            data_reg <= '0;
        end else begin
            idx_reg <= idx_next;
            if (load) data_reg <= lookup_data;
        end
    end

    assign dump_idx  = idx_reg;
    assign dump_data = data_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, busy scoreboard, prioritised writeback with read bypass,
// and the dump engine reading through the same bypassed view.
module regfile_mp import regfile_pkg::*; #(
    parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int NUM_RD         = DEF_NUM_RD,
    parameter int NUM_WR         = DEF_NUM_WR
) (
    input logic         clk,
    input logic         reset_n,
    regfile_mp_if.slave bus
);
    localparam int BDW = BUS_DATA_WIDTH;
    localparam int AW  = reg_idx_w(NUM_REGS);

    // view is each register as it will be after this edge's writeback.
    logic [NUM_REGS-1:0][BDW-1:0] view;
    logic [NUM_REGS-1:0]          busy_next;
    logic [AW-1:0]                lookup_idx;
    logic [BDW-1:0]               lookup_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign view[gi]      = '0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic [BDW-1:0] val_reg;
                logic [BDW-1:0] val_next;
                logic           busy_reg;
                logic           wr_hit;
                logic           issue_hit;

                // Ascending scan so the highest-numbered matching port wins.
                always_comb begin
                    wr_hit   = 1'b0;
                    val_next = val_reg;
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(gi)) begin
                            wr_hit   = 1'b1;
                            val_next = bus.wr_data[w*BDW +: BDW];
                        end
                    end
                end

                assign issue_hit     = bus.issue_en && (bus.issue_rd == AW'(gi));
                assign busy_next[gi] = issue_hit ? 1'b1 : (wr_hit ? 1'b0 : busy_reg);
                assign view[gi]      = val_next;

                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        val_reg  <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        val_reg  <= val_next;
                        busy_reg <= busy_next[gi];
                    end
                end
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]  addr;
            logic [BDW-1:0] data_reg;
            logic           busy_reg;

            assign addr = bus.rd_addr[gi*AW +: AW];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    data_reg <= '0;
                    busy_reg <= 1'b0;
                end else if (bus.rd_en) begin
                    if (bus.rd_imm_sel[gi]) begin
                        data_reg <= bus.rd_imm[gi*BDW +: BDW];
                        busy_reg <= 1'b0;
                    end else begin
                        data_reg <= view[addr];
                        busy_reg <= busy_next[addr];
                    end
                end
            end

            assign bus.rd_data[gi*BDW +: BDW] = data_reg;
            assign bus.rd_busy[gi]            = busy_reg;
        end
    endgenerate

    assign lookup_data = view[lookup_idx];

    regfile_dump_fsm #(
        .NUM_REGS (NUM_REGS),
        .BDW      (BDW)
    ) u_dump (
        .clk         (clk),
        .reset_n     (reset_n),
        .dump_req    (bus.dump_req),
        .dump_ready  (bus.dump_ready),
        .lookup_idx  (lookup_idx),
        .lookup_data (lookup_data),
        .dump_valid  (bus.dump_valid),
        .dump_idx    (bus.dump_idx),
        .dump_data   (bus.dump_data),
        .dump_done   (bus.dump_done)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scenario bench for regfile_mp with two write ports, directed checks plus a randomized run
// against an array-based reference model of the architectural state.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int BDW   = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.BDW(BDW), .AW(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    regfile_mp #(
        .BUS_DATA_WIDTH (BDW),
        .NUM_REGS       (NREGS),
        .NUM_RD         (NRD),
        .NUM_WR         (NWR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [BDW-1:0] m_regs [NREGS];
    bit             m_busy [NREGS];
    logic [BDW-1:0] e_data [NRD];
    logic           e_busy [NRD];
    int total = 0;
    int bad   = 0;

    task automatic clear_inputs();
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_imm_sel = '0;
        bus.rd_imm     = '0;
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_rd   = '0;
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a, input logic sel, input logic [BDW-1:0] imm);
        bus.rd_addr[p*AW +: AW]    = a;
        bus.rd_imm_sel[p]          = sel;
        bus.rd_imm[p*BDW +: BDW]   = imm;
    endtask

    task automatic set_wr(input int w, input logic en, input logic [AW-1:0] a, input logic [BDW-1:0] d);
        bus.wr_en[w]               = en;
        bus.wr_addr[w*AW +: AW]    = a;
        bus.wr_data[w*BDW +: BDW]  = d;
    endtask

    // Reference model: architectural registers as an array, advanced one clock at a time.
    task automatic step();
        logic [AW-1:0]  a;
        logic [BDW-1:0] v;
        bit             written;
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            for (int p = 0; p < NRD; p++) begin
                e_data[p] = '0;
                e_busy[p] = 1'b0;
            end
        end else begin
            if (bus.rd_en) begin
                for (int p = 0; p < NRD; p++) begin
                    a = bus.rd_addr[p*AW +: AW];
                    if (bus.rd_imm_sel[p]) begin
                        e_data[p] = bus.rd_imm[p*BDW +: BDW];
                        e_busy[p] = 1'b0;
                    end else begin
                        v = m_regs[a];
                        written = 1'b0;
                        for (int w = 0; w < NWR; w++) begin
                            if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) begin
                                v = bus.wr_data[w*BDW +: BDW];
                                written = 1'b1;
                            end
                        end
                        e_data[p] = (a == 0) ? '0 : v;
                        e_busy[p] = (a != 0) && ((bus.issue_en && bus.issue_rd == a) || (!written && m_busy[a]));
                    end
                end
            end
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != 0) begin
                    m_regs[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*BDW +: BDW];
                    m_busy[bus.wr_addr[w*AW +: AW]] = 1'b0;
                end
            end
            if (bus.issue_en && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        bus.rd_en = 1'b1;
        bus.dump_req = 1'b1;
        bus.dump_ready = 1'b1;
        step();
        step();
        total++; if (bus.rd_data !== '0)   begin bad++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        total++; if (bus.rd_busy !== '0)   begin bad++; $display("FAIL reset_rd_busy got=%b exp=0", bus.rd_busy); end
        total++; if (bus.dump_valid !== 0) begin bad++; $display("FAIL reset_dump_valid got=%b exp=0", bus.dump_valid); end
        total++; if (bus.dump_idx !== '0)  begin bad++; $display("FAIL reset_dump_idx got=%0d exp=0", bus.dump_idx); end
        total++; if (bus.dump_data !== '0) begin bad++; $display("FAIL reset_dump_data got=%h exp=0", bus.dump_data); end
        total++; if (bus.dump_done !== 0)  begin bad++; $display("FAIL reset_dump_done got=%b exp=0", bus.dump_done); end
        clear_inputs();
        reset_n = 1'b1;
        step();
        $display("reset: checked");
    endtask

    task automatic test_read_basic();
        clear_inputs();
        bus.rd_en = 1'b1;
        set_rd(0, 5, 0, '0);
        set_rd(1, 7, 0, '0);
        step();
        total++; if (bus.rd_data[0 +: BDW] !== 64'h0)   begin bad++; $display("FAIL read_r5 got=%h exp=0", bus.rd_data[0 +: BDW]); end
        total++; if (bus.rd_data[BDW +: BDW] !== 64'h0) begin bad++; $display("FAIL read_r7 got=%h exp=0", bus.rd_data[BDW +: BDW]); end
        total++; if (bus.rd_busy !== 2'b00)             begin bad++; $display("FAIL read_busy got=%b exp=00", bus.rd_busy); end
        set_wr(0, 1, 0, 64'hDEAD);
        set_rd(0, 0, 0, '0);
        step();
        total++; if (bus.rd_data[0 +: BDW] !== 64'h0) begin bad++; $display("FAIL r0_bypass got=%h exp=0", bus.rd_data[0 +: BDW]); end
        clear_inputs();
        bus.rd_en = 1'b1;
        step();
        total++; if (bus.rd_data[0 +: BDW] !== 64'h0) begin bad++; $display("FAIL r0_stored got=%h exp=0", bus.rd_data[0 +: BDW]); end
        $display("read_basic: r5/r7 and r0 write ignored");
    endtask

    task automatic test_bypass();
        clear_inputs();
        bus.rd_en = 1'b1;
        set_wr(0, 1, 5, 64'h1234);
        set_rd(0, 5, 0, '0);
        set_rd(1, 7, 0, '0);
        step();
        total++; if (bus.rd_data[0 +: BDW] !== 64'h1234) begin bad++; $display("FAIL bypass_r5 got=%h exp=1234", bus.rd_data[0 +: BDW]); end
        total++; if (bus.rd_data[BDW +: BDW] !== 64'h0)  begin bad++; $display("FAIL bypass_r7 got=%h exp=0", bus.rd_data[BDW +: BDW]); end
        clear_inputs();
        bus.rd_en = 1'b1;
        set_rd(1, 5, 0, '0);
        step();
        total++; if (bus.rd_data[BDW +: BDW] !== 64'h1234) begin bad++; $display("FAIL stored_r5 got=%h exp=1234", bus.rd_data[BDW +: BDW]); end
        $display("bypass: write r5=1234 visible same cycle");
    endtask

    task automatic test_write_conflict();
        clear_inputs();
        bus.rd_en = 1'b1;
        set_wr(0, 1, 3, 64'hAA);
        set_wr(1, 1, 3, 64'hBB);
        set_rd(0, 3, 0, '0);
        step();
        total++; if (bus.rd_data[0 +: BDW] !== 64'hBB) begin bad++; $display("FAIL conflict_bypass got=%h exp=bb", bus.rd_data[0 +: BDW]); end
        clear_inputs();
        bus.rd_en = 1'b1;
        set_rd(0, 3, 0, '0);
        set_rd(1, 3, 0, '0);
        step();
        total++; if (bus.rd_data[BDW +: BDW] !== 64'hBB) begin bad++; $display("FAIL conflict_stored got=%h exp=bb", bus.rd_data[BDW +: BDW]); end
        $display("write_conflict: port1 wins r3=bb");
    endtask

    task automatic test_busy();
        clear_inputs();
        bus.rd_en = 1'b1;
        bus.issue_en = 1'b1;
        bus.issue_rd = 9;
        set_rd(0, 9, 0, '0);
        step();
        total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL busy_issue_same got=%b exp=1", bus.rd_busy[0]); end
        bus.issue_en = 1'b0;
        step();
        total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL busy_after_issue got=%b exp=1", bus.rd_busy[0]); end
        set_wr(0, 1, 9, 64'h55);
        step();
        total++; if (bus.rd_busy[0] !== 1'b0)          begin bad++; $display("FAIL busy_wr_bypass got=%b exp=0", bus.rd_busy[0]); end
        total++; if (bus.rd_data[0 +: BDW] !== 64'h55) begin bad++; $display("FAIL data_wr_bypass got=%h exp=55", bus.rd_data[0 +: BDW]); end
        set_wr(0, 0, 0, '0);
        step();
        total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL busy_cleared got=%b exp=0", bus.rd_busy[0]); end
        bus.issue_en = 1'b1;
        set_wr(1, 1, 9, 64'h66);
        step();
        total++; if (bus.rd_busy[0] !== 1'b1)          begin bad++; $display("FAIL busy_issue_wr got=%b exp=1", bus.rd_busy[0]); end
        total++; if (bus.rd_data[0 +: BDW] !== 64'h66) begin bad++; $display("FAIL data_issue_wr got=%h exp=66", bus.rd_data[0 +: BDW]); end
        bus.issue_en = 1'b0;
        set_wr(1, 0, 0, '0);
        step();
        total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL busy_stays got=%b exp=1", bus.rd_busy[0]); end
        bus.issue_en = 1'b1;
        bus.issue_rd = 0;
        set_rd(1, 0, 0, '0);
        step();
        total++; if (bus.rd_busy[1] !== 1'b0) begin bad++; $display("FAIL busy_r0 got=%b exp=0", bus.rd_busy[1]); end
        $display("busy: issue/write/issue+write on r9, r0 never busy");
    endtask

    task automatic test_imm_and_hold();
        clear_inputs();
        bus.rd_en = 1'b1;
        set_rd(0, 9, 0, '0);
        set_rd(1, 9, 1, 64'hFFFF_0000);
        step();
        total++; if (bus.rd_data[BDW +: BDW] !== 64'hFFFF_0000) begin bad++; $display("FAIL imm_data got=%h exp=ffff0000", bus.rd_data[BDW +: BDW]); end
        total++; if (bus.rd_busy !== 2'b01)                     begin bad++; $display("FAIL imm_busy got=%b exp=01", bus.rd_busy); end
        bus.rd_en = 1'b0;
        set_rd(0, 3, 0, '0);
        set_rd(1, 5, 0, '0);
        step();
        total++; if (bus.rd_data[0 +: BDW] !== 64'h66)          begin bad++; $display("FAIL hold_p0 got=%h exp=66", bus.rd_data[0 +: BDW]); end
        total++; if (bus.rd_data[BDW +: BDW] !== 64'hFFFF_0000) begin bad++; $display("FAIL hold_p1 got=%h exp=ffff0000", bus.rd_data[BDW +: BDW]); end
        $display("imm_and_hold: immediate on port1, outputs hold with rd_en=0");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = bad;
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            bus.rd_en = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NRD; p++)
                set_rd(p, ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS-1)) : AW'($urandom_range(0, 7)),
                       ($urandom_range(0, 4) == 0), {$urandom(), $urandom()});
            for (int w = 0; w < NWR; w++)
                set_wr(w, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), {$urandom(), $urandom()});
            bus.issue_en = ($urandom_range(0, 2) == 0);
            bus.issue_rd = AW'($urandom_range(0, 7));
            step();
            for (int p = 0; p < NRD; p++) begin
                total++; if (bus.rd_data[p*BDW +: BDW] !== e_data[p]) begin bad++; $display("FAIL rand_data[%0d] n=%0d got=%h exp=%h", p, n, bus.rd_data[p*BDW +: BDW], e_data[p]); end
                total++; if (bus.rd_busy[p] !== e_busy[p])           begin bad++; $display("FAIL rand_busy[%0d] n=%0d got=%b exp=%b", p, n, bus.rd_busy[p], e_busy[p]); end
            end
        end
        $display("random: 400 cycles, new errors=%0d", bad - errs_before);
    endtask

    task automatic test_dump();
        int  beat, done_cnt, cyc;
        bit  finished, stalled, accept;
        logic [BDW-1:0] held;
        clear_inputs();
        for (int i = 1; i < NREGS; i += 2) begin
            set_wr(0, 1, AW'(i), 64'(i * 3));
            set_wr(1, (i + 1) < NREGS, AW'(i + 1), 64'((i + 1) * 3));
            step();
        end
        clear_inputs();
        bus.dump_req = 1'b1;
        step();
        bus.dump_req = 1'b0;
        beat = 0; done_cnt = 0; cyc = 0; finished = 0; stalled = 0; held = '0;
        while (cyc < 300 && !finished) begin
            if (bus.dump_valid) begin
                total++; if (bus.dump_idx !== AW'(beat)) begin bad++; $display("FAIL dump_idx got=%0d exp=%0d", bus.dump_idx, beat); end
                total++;
                if (beat >= NREGS) begin bad++; $display("FAIL dump_extra_beat got=%0d exp<%0d", beat, NREGS); end
                else if (bus.dump_data !== m_regs[beat]) begin bad++; $display("FAIL dump_data[%0d] got=%h exp=%h", beat, bus.dump_data, m_regs[beat]); end
                if (stalled) begin
                    total++; if (bus.dump_data !== held) begin bad++; $display("FAIL dump_stall_hold got=%h exp=%h", bus.dump_data, held); end
                end
            end
            if (bus.dump_done) begin
                done_cnt++;
                finished = 1;
                total++; if (beat !== NREGS) begin bad++; $display("FAIL dump_done_early got=%0d beats exp=%0d", beat, NREGS); end
            end
            clear_inputs();
            bus.dump_ready = (cyc % 2 == 0);
            if (cyc == 4) set_wr(1, 1, 20, 64'hABCD_0000_1234);
            if (cyc == 6) bus.dump_req = 1'b1;
            accept  = bus.dump_valid && bus.dump_ready;
            stalled = bus.dump_valid && !bus.dump_ready;
            held    = bus.dump_data;
            step();
            if (accept) beat++;
            cyc++;
        end
        total++; if (!finished)           begin bad++; $display("FAIL dump_timeout got=%0d beats exp=%0d", beat, NREGS); end
        total++; if (bus.dump_done !== 0) begin bad++; $display("FAIL dump_done_width got=%b exp=0", bus.dump_done); end
        total++; if (bus.dump_valid !== 0) begin bad++; $display("FAIL dump_valid_after got=%b exp=0", bus.dump_valid); end
        $display("dump: beats=%0d done_pulses=%0d cycles=%0d", beat, done_cnt, cyc);
    endtask

    task automatic test_dump_reset();
        int cyc;
        clear_inputs();
        bus.dump_req = 1'b1;
        bus.dump_ready = 1'b1;
        step();
        bus.dump_req = 1'b0;
        cyc = 0;
        while (cyc < 50 && !(bus.dump_valid && bus.dump_idx == AW'(10))) begin
            step();
            cyc++;
        end
        total++; if (cyc >= 50) begin bad++; $display("FAIL dump_reach_10 got=%0d exp=10", bus.dump_idx); end
        reset_n = 1'b0;
        step();
        total++; if (bus.dump_valid !== 0) begin bad++; $display("FAIL rst_dump_valid got=%b exp=0", bus.dump_valid); end
        total++; if (bus.dump_idx !== '0)  begin bad++; $display("FAIL rst_dump_idx got=%0d exp=0", bus.dump_idx); end
        total++; if (bus.dump_data !== '0) begin bad++; $display("FAIL rst_dump_data got=%h exp=0", bus.dump_data); end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.dump_valid !== 0) begin bad++; $display("FAIL rst_dump_idle got=%b exp=0", bus.dump_valid); end
        end
        bus.rd_en = 1'b1;
        set_rd(0, 3, 0, '0);
        set_rd(1, 20, 0, '0);
        step();
        total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL rst_regs_cleared got=%h exp=0", bus.rd_data); end
        $display("dump_reset: aborted at beat 10, FSM idle");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_read_basic();
        test_bypass();
        test_write_conflict();
        test_busy();
        test_imm_and_hold();
        test_random();
        test_dump();
        test_dump_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
